// File: rtl/player_input_ctrl_if.sv
// Keyboard and round-control bundle feeding player_input_ctrl.
// The keyboard decoder/game core side drives it through the master modport.
interface player_input_ctrl_if;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         round_start;
    logic         round_end;
    logic         move_tick;

    modport master (
        output key_valid, last_change, key_down,
        output round_start, round_end, move_tick
    );

    modport slave (
        input key_valid, last_change, key_down,
        input round_start, round_end, move_tick
    );
endinterface

// File: rtl/player_input_ctrl.sv
// Two-player turn queueing from PS/2 key events, committed on move ticks.
// Define ARROW_KEYS_EN to map player2 onto the arrow keys instead of I/J/K/L.
module player_input_ctrl (
    input  logic               clk,
    input  logic               rst,
    player_input_ctrl_if.slave bus,
    output logic [1:0]         player1_dir,
    output logic [1:0]         player2_dir,
    output logic [1:0]         p1_qcnt,
    output logic [1:0]         p2_qcnt,
    output logic               q_ovf,
    output logic               running,
    output logic               led_w,
    output logic               led_a,
    output logic               led_s,
    output logic               led_d
);

    localparam logic [8:0] K_W = 9'h01D;
    localparam logic [8:0] K_D = 9'h023;
    localparam logic [8:0] K_S = 9'h01B;
    localparam logic [8:0] K_A = 9'h01C;

`ifdef ARROW_KEYS_EN
    localparam logic [8:0] K2_UP = 9'h175;
    localparam logic [8:0] K2_RT = 9'h174;
    localparam logic [8:0] K2_DN = 9'h172;
    localparam logic [8:0] K2_LT = 9'h16B;
`else
    localparam logic [8:0] K2_UP = 9'h043;
    localparam logic [8:0] K2_RT = 9'h04B;
    localparam logic [8:0] K2_DN = 9'h042;
    localparam logic [8:0] K2_LT = 9'h03B;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    // q0 is the head; q1 is only meaningful when cnt == 2
    typedef struct packed {
        logic [1:0] dir;
        logic [1:0] q0;
        logic [1:0] q1;
        logic [1:0] cnt;
    } pq_t;

    localparam pq_t P1_RST = '{dir: 2'b01, q0: 2'b00, q1: 2'b00, cnt: 2'd0};
    localparam pq_t P2_RST = '{dir: 2'b11, q0: 2'b00, q1: 2'b00, cnt: 2'd0};

    state_t state_q, state_d;
    pq_t    p1_q, p2_q, p1_n, p2_n;
    logic   ovf_q, ovf1, ovf2;
    logic   press, run_ops;
    logic   c1v, c2v;
    logic [1:0] c1d, c2d;
    logic [3:0] led_q;

    // Returns {overflow, next queue state}
    function automatic logic [8:0] step(
        input pq_t        c,
        input logic       cv,
        input logic [1:0] cd,
        input logic       tick
    );
        pq_t        n;
        logic [1:0] rd;
        logic [1:0] slot;
        logic       pop, legal, push, ovf;
        n     = c;
        rd    = (c.cnt == 2'd0) ? c.dir :
                (c.cnt == 2'd1) ? c.q0 : c.q1;
        pop   = tick && (c.cnt != 2'd0);
        legal = cv && (cd != rd) && (cd != (rd ^ 2'b10));
        push  = legal && ((c.cnt != 2'd2) || pop);
        ovf   = legal && !push;
        slot  = c.cnt - {1'b0, pop};
        if (pop) begin
            n.dir = c.q0;
            n.q0  = c.q1;
        end
        if (push) begin
            if (slot == 2'd0) n.q0 = cd;
            else              n.q1 = cd;
        end
        n.cnt = c.cnt + {1'b0, push} - {1'b0, pop};
        return {ovf, n};
    endfunction

    always_comb begin
        press = bus.key_valid && bus.key_down[bus.last_change];
        c1v = 1'b0;
        c1d = 2'b00;
        c2v = 1'b0;
        c2d = 2'b00;
        unique case (1'b1)
            (bus.last_change == K_W):   begin c1v = press; c1d = 2'b00; end
            (bus.last_change == K_D):   begin c1v = press; c1d = 2'b01; end
            (bus.last_change == K_S):   begin c1v = press; c1d = 2'b10; end
            (bus.last_change == K_A):   begin c1v = press; c1d = 2'b11; end
            (bus.last_change == K2_UP): begin c2v = press; c2d = 2'b00; end
            (bus.last_change == K2_RT): begin c2v = press; c2d = 2'b01; end
            (bus.last_change == K2_DN): begin c2v = press; c2d = 2'b10; end
            (bus.last_change == K2_LT): begin c2v = press; c2d = 2'b11; end
            default: ;
        endcase
    end

    // A round_start reload overrides any push/pop in the same cycle
    always_comb begin
        run_ops = (state_q == RUN) && !bus.round_start;
        {ovf1, p1_n} = step(p1_q, c1v && run_ops, c1d,
                            bus.move_tick && run_ops);
        {ovf2, p2_n} = step(p2_q, c2v && run_ops, c2d,
                            bus.move_tick && run_ops);
    end

    always_comb begin
        state_d = state_q;
        running = (state_q == RUN);
        unique case (state_q)
            IDLE: if (bus.round_start && !bus.round_end) state_d = RUN;
            RUN:  if (bus.round_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p1_q    <= P1_RST;
            p2_q    <= P2_RST;
            ovf_q   <= 1'b0;
            led_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (bus.round_start) begin
                p1_q <= P1_RST;
                p2_q <= P2_RST;
            end else begin
                p1_q  <= p1_n;
                p2_q  <= p2_n;
                ovf_q <= ovf_q | ovf1 | ovf2;
            end
            led_q <= {bus.key_down[K_W], bus.key_down[K_A],
                      bus.key_down[K_S], bus.key_down[K_D]};
        end
    end

    assign player1_dir = p1_q.dir;
    assign player2_dir = p2_q.dir;
    assign p1_qcnt     = p1_q.cnt;
    assign p2_qcnt     = p2_q.cnt;
    assign q_ovf       = ovf_q;
    assign {led_w, led_a, led_s, led_d} = led_q;

endmodule
